upload_write_scheduler: RTL

//  Sequences result uploads from PL into PS DDR through the single-ID AXI write command/stream engine.

---
 rtl/upload_write_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/upload_write_scheduler.sv
// upload_write_scheduler: splits one upload request into write commands that
// never exceed or straddle a CHUNK_BYTES-aligned window, frames the upstream
// beat stream with last at every chunk end and waits for the write engine's
// completion of each chunk before issuing the next one.
// Stream handshake: a beat moves when valid && ready are both high at the
// rising clock edge; valid never waits on ready, and in DATA the upstream and
// downstream handshakes are the same event because the path is combinational.
module upload_write_scheduler #(
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 32,
   parameter int DATA_W      = 64,
   parameter int CHUNK_BYTES = 4096,
   parameter int TIMEOUT_CYC = 2**20
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_nbyte,
   output logic              done_pulse,
   output logic              busy,
   output logic              err_align,
   output logic              err_timeout,
   input  logic              err_clr,
   output logic              write_cmd_start,
   output logic [ADDR_W-1:0] write_cmd_addr,
   output logic [LEN_W-1:0]  write_cmd_len,
   input  logic              write_cmd_done,
   input  logic              s_axis_valid,
   output logic              s_axis_ready,
   input  logic [DATA_W-1:0] s_axis_data,
   output logic              m_axis_valid,
   input  logic              m_axis_ready,
   output logic [DATA_W-1:0] m_axis_data,
   output logic              m_axis_last
);
   localparam int BYTES = DATA_W / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_W-1:0] ADDR_BMASK = ADDR_W'(BYTES - 1);
   localparam logic [31:0]       NB_BMASK   = 32'(BYTES - 1);
   localparam logic [ADDR_W-1:0] ADDR_CMASK = ADDR_W'(CHUNK_BYTES - 1);
   localparam logic [TW-1:0]     TMO_LIMIT  = TW'(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_WAIT, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [31:0]       remain_q, remain_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              done_seen_q, done_seen_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              err_timeout_q, err_timeout_d;

   logic [LEN_W-1:0]  room_w, chunk_w, beats_m1_w;
   logic [31:0]       remain_next_w;
   logic [TW-1:0]     tmo_inc_w;
   logic              beat_last_w;

   // Chunk sizing, last-beat detection and post-chunk bookkeeping values
   always_comb begin
      room_w        = LEN_W'(CHUNK_BYTES) - LEN_W'(cur_addr_q & ADDR_CMASK);
      chunk_w       = (LEN_W'(remain_q) < room_w) ? LEN_W'(remain_q) : room_w;
      beats_m1_w    = (cmd_len_q >> BSH) - LEN_W'(1);
      beat_last_w   = (beat_cnt_q == beats_m1_w);
      remain_next_w = remain_q - 32'(cmd_len_q);
      tmo_inc_w     = tmo_q + TW'(1);
   end

   // Next-state and output decode; the timeout watchdog overrides the FSM last
   always_comb begin
      state_d         = state_q;
      cur_addr_d      = cur_addr_q;
      remain_d        = remain_q;
      cmd_addr_d      = cmd_addr_q;
      cmd_len_d       = cmd_len_q;
      beat_cnt_d      = beat_cnt_q;
      done_seen_d     = done_seen_q;
      tmo_d           = '0;
      err_timeout_d   = err_timeout_q & ~err_clr;
      req_ready       = 1'b0;
      done_pulse      = 1'b0;
      err_align       = 1'b0;
      write_cmd_start = 1'b0;
      write_cmd_addr  = cmd_addr_q;
      write_cmd_len   = cmd_len_q;
      s_axis_ready    = 1'b0;
      m_axis_valid    = 1'b0;
      m_axis_data     = '0;
      m_axis_last     = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = ~sys_rst;
            if (req_valid && !sys_rst) begin
               if (((req_addr & ADDR_BMASK) != '0) || ((req_nbyte & NB_BMASK) != '0)) begin
                  err_align = 1'b1;
               end else begin
                  cur_addr_d = req_addr;
                  remain_d   = req_nbyte;
                  state_d    = (req_nbyte == '0) ? S_FIN : S_CMD;
               end
            end
         end
         S_CMD: begin
            write_cmd_start = 1'b1;
            write_cmd_addr  = cur_addr_q;
            write_cmd_len   = chunk_w;
            cmd_addr_d      = cur_addr_q;
            cmd_len_d       = chunk_w;
            beat_cnt_d      = '0;
            done_seen_d     = 1'b0;
            state_d         = S_DATA;
         end
         S_DATA: begin
            m_axis_valid = s_axis_valid;
            s_axis_ready = m_axis_ready;
            m_axis_data  = s_axis_data;
            m_axis_last  = beat_last_w;
            if (write_cmd_done) done_seen_d = 1'b1;
            if (s_axis_valid && m_axis_ready) begin
               beat_cnt_d = beat_cnt_q + LEN_W'(1);
               if (beat_last_w) begin
                  beat_cnt_d = '0;
                  state_d    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (done_seen_q || write_cmd_done) begin
               cur_addr_d  = cur_addr_q + ADDR_W'(cmd_len_q);
               remain_d    = remain_next_w;
               done_seen_d = 1'b0;
               state_d     = (remain_next_w == '0) ? S_FIN : S_CMD;
            end
         end
         S_FIN: begin
            done_pulse = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q == S_DATA || state_q == S_WAIT) begin
         if ((state_q == S_DATA && s_axis_valid && m_axis_ready) || write_cmd_done) begin
            tmo_d = '0;
         end else if (tmo_inc_w == TMO_LIMIT) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
         end else begin
            tmo_d = tmo_inc_w;
         end
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign err_timeout = err_timeout_q;

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q       <= S_IDLE;
         cur_addr_q    <= '0;
         remain_q      <= '0;
         cmd_addr_q    <= '0;
         cmd_len_q     <= '0;
         beat_cnt_q    <= '0;
         done_seen_q   <= 1'b0;
         tmo_q         <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_addr_q    <= cur_addr_d;
         remain_q      <= remain_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_len_q     <= cmd_len_d;
         beat_cnt_q    <= beat_cnt_d;
         done_seen_q   <= done_seen_d;
         tmo_q         <= tmo_d;
         err_timeout_q <= err_timeout_d;
      end
   end
endmodule
